multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main control state machine for the multicycle version of the processor. It replaces the single-cycle main decoder with a sequenced controller that drives the shared ALU, the shared instruction/data memory port, the instruction register, the PC and the register file over several cycles per instruction. It decodes the same op/funct fields (data-processing register and immediate, LDR/STR, B) and waits on a memory-ready handshake. Its reg_w, mem_w and branch strobes are unconditioned; the condition-check logic downstream gates them.

## Interface
- No parameters. State encoding is fixed (see Operation).
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- op  input  2  instr[27:26] from the instruction register
- funct  input  6  instr[25:20] from the instruction register; only funct[5] (I) and funct[0] (L) are used
- mem_ready  input  1  memory port completes the current access this cycle
- ir_w  output  1  instruction register write enable
- next_pc  output  1  PC write enable (PC <= ALU result)
- adr_src  output  1  memory address: 0 = PC, 1 = ALU result register
- alu_src_a  output  1  0 = register A, 1 = PC
- alu_src_b  output  2  00 = register B, 01 = extended immediate, 10 = constant 4
- alu_op  output  1  1 = ALU decoder uses funct, 0 = force ADD
- result_src  output  2  00 = ALU result register, 01 = memory data register, 10 = ALU output
- imm_src  output  2  00 = DP imm8, 01 = mem imm12, 10 = branch imm24; combinational from op
- reg_w  output  1  register file write strobe
- mem_w  output  1  memory write request
- branch  output  1  branch PC-write strobe
- illegal  output  1  one-cycle pulse: op = 11 decoded
- instr_done  output  1  one-cycle pulse on the last cycle of every instruction
- state  output  4  current state (debug/verification)

## Operation
- States/encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10-15 are unreachable; if entered, the next state is FETCH.
- Outputs are Moore on state, except the strobes gated by mem_ready as noted. Unlisted outputs are 0.
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, alu_op=0, result_src=10. ir_w=next_pc=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, alu_op=0, result_src=10. Next state by op:
  - 01 -> MEMADR
  - 00 with funct[5]=0 -> EXECUTER
  - 00 with funct[5]=1 -> EXECUTEI
  - 10 -> BRANCH
  - 11 -> FETCH, with illegal=1 and instr_done=1
- MEMADR: alu_src_a=0, alu_src_b=01, alu_op=0. funct[0]=1 -> MEMREAD; funct[0]=0 -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_w=1, instr_done=1. Then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_w=1 for every cycle in the state. Holds until mem_ready=1. instr_done=mem_ready. Then FETCH.
- EXECUTER: alu_src_a=0, alu_src_b=00, alu_op=1. Then ALUWB.
- EXECUTEI: alu_src_a=0, alu_src_b=01, alu_op=1. Then ALUWB.
- ALUWB: result_src=00, reg_w=1, instr_done=1. Then FETCH.
- BRANCH: alu_src_a=0, alu_src_b=01, alu_op=0, result_src=10, branch=1, instr_done=1. Then FETCH.
- imm_src: op 00 -> 00, 01 -> 01, 10 -> 10, 11 -> 00. Independent of state.
- op/funct are only sampled in DECODE and MEMADR; changes in other states have no effect.

## Timing
- Reset:
  - state = FETCH immediately (asynchronous).
  - While rst=1: ir_w, next_pc, reg_w, mem_w, branch, illegal and instr_done are forced to 0. Selects hold their FETCH values.
  - First possible ir_w is the first rising edge after rst falls, with mem_ready=1.
  - Reset mid-instruction abandons the instruction with no strobe issued.
- Cycle counts with zero wait states (mem_ready held 1):
  - LDR: 5 cycles
  - STR: 4 cycles
  - DP reg or imm: 4 cycles
  - B: 3 cycles
  - illegal: 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable while waiting. ir_w and next_pc never pulse while waiting.
- Exactly one instr_done pulse per instruction. reg_w, branch, ir_w and next_pc are each high for at most one cycle per instruction.

## Test plan
- Reset mid-MEMREAD: assert rst asynchronously -> state=0 within the same cycle, all strobes 0. Release with mem_ready=1 -> ir_w=1 on the first cycle after release.
- DP sequence, mem_ready=1: op=00, funct=000000 -> states 0,1,6,8,0 with alu_op=1 and alu_src_b=00 in state 6. Then funct=100000 -> states 0,1,7,8 with alu_src_b=01, imm_src=00, reg_w=1 only in state 8.
- LDR with 2 wait cycles in MEMREAD: op=01, funct[0]=1 -> states 0,1,2,3,3,3,4. mem_to-reg path: result_src=01 and reg_w=1 in state 4. Total 7 cycles, one instr_done.
- STR with 1 wait cycle in FETCH: op=01, funct[0]=0 -> states 0,0,1,2,5,0. ir_w=1 only on the second FETCH cycle. mem_w=1 only in state 5, and reg_w is never 1.
- Branch: op=10, any funct -> states 0,1,9,0 with branch=1, alu_src_b=01, imm_src=10, result_src=10 in state 9.
- Illegal: op=11 -> states 0,1,0 with illegal=1 and instr_done=1 in DECODE, and no reg_w, mem_w or branch asserted.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle main controller and the datapath.
interface multicycle_control_fsm_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       ir_w;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       illegal;
    logic       instr_done;
    logic [3:0] state;

    // Controller side: consumes instruction fields and memory handshake.
    modport master (
        input  op, funct, mem_ready,
        output ir_w, next_pc, adr_src, alu_src_a, alu_src_b, alu_op,
               result_src, imm_src, reg_w, mem_w, branch, illegal,
               instr_done, state
    );

    // Datapath side: supplies instruction fields, consumes controls.
    modport slave (
        output op, funct, mem_ready,
        input  ir_w, next_pc, adr_src, alu_src_a, alu_src_b, alu_op,
               result_src, imm_src, reg_w, mem_w, branch, illegal,
               instr_done, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Sequenced main controller for the multicycle processor: fetch, decode,
// memory / execute / branch phases, with a memory-ready handshake.
module multicycle_control_fsm (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_control_fsm_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       ir_w;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       illegal;
    logic       instr_done;

    // Only I (funct[5]) and L (funct[0]) steer the sequence.
    logic       unused_funct;
    assign unused_funct = ^bus.funct[4:1];

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore decode; FETCH/MEMWRITE strobes follow mem_ready.
    always_comb begin
        state_d    = state_q;
        ir_w       = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 1'b0;
        result_src = 2'b00;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_w       = bus.mem_ready;
                next_pc    = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (bus.op)
                    2'b00:   state_d = bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        state_d    = S_FETCH;
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                instr_done = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        case (bus.op)
            2'b01:   bus.imm_src = 2'b01;
            2'b10:   bus.imm_src = 2'b10;
            default: bus.imm_src = 2'b00;
        endcase
    end

    // Strobes are suppressed while reset is held; selects pass straight out.
    assign bus.ir_w       = ir_w       & ~rst;
    assign bus.next_pc    = next_pc    & ~rst;
    assign bus.reg_w      = reg_w      & ~rst;
    assign bus.mem_w      = mem_w      & ~rst;
    assign bus.branch     = branch     & ~rst;
    assign bus.illegal    = illegal    & ~rst;
    assign bus.instr_done = instr_done & ~rst;
    assign bus.adr_src    = adr_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.result_src = result_src;
    assign bus.state      = 4'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed and random instruction streams
// checked against an instruction-level reference of the expected trace.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Datapath selects expected for each state: {adr_src, alu_src_a, alu_src_b, alu_op, result_src}.
    function automatic logic [6:0] exp_sel(input logic [3:0] s);
        case (s)
            4'd0, 4'd1: return {1'b0, 1'b1, 2'b10, 1'b0, 2'b10};
            4'd2:       return {1'b0, 1'b0, 2'b01, 1'b0, 2'b00};
            4'd3, 4'd5: return {1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
            4'd4:       return {1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
            4'd6:       return {1'b0, 1'b0, 2'b00, 1'b1, 2'b00};
            4'd7:       return {1'b0, 1'b0, 2'b01, 1'b1, 2'b00};
            4'd9:       return {1'b0, 1'b0, 2'b01, 1'b0, 2'b10};
            default:    return 7'd0;
        endcase
    endfunction

    function automatic logic [6:0] obs_sel();
        return {bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src};
    endfunction

    // {ir_w, next_pc, reg_w, mem_w, branch, illegal, instr_done}
    function automatic logic [6:0] obs_strb();
        return {bus.ir_w, bus.next_pc, bus.reg_w, bus.mem_w, bus.branch, bus.illegal, bus.instr_done};
    endfunction

    // Runs one instruction from cycle start (posedge+1, DUT in FETCH).
    // wf = FETCH wait cycles, wm = MEMREAD/MEMWRITE wait cycles.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input int wf, input int wm, input string name);
        logic [3:0] exp_q[$];
        logic [6:0] es;
        logic [1:0] eimm;
        int last;
        int mem_first;
        bit done;
        for (int i = 0; i <= wf; i++) exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        mem_first = wf + 3;
        case (op)
            2'b00: begin
                exp_q.push_back(funct[5] ? 4'd7 : 4'd6);
                exp_q.push_back(4'd8);
            end
            2'b01: begin
                exp_q.push_back(4'd2);
                for (int i = 0; i <= wm; i++) exp_q.push_back(funct[0] ? 4'd3 : 4'd5);
                if (funct[0]) exp_q.push_back(4'd4);
            end
            2'b10: exp_q.push_back(4'd9);
            default: ;
        endcase
        eimm = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        last = exp_q.size() - 1;
        for (int c = 0; c <= last; c++) begin
            bus.op    = op;
            bus.funct = (c == wf + 1 || c == wf + 2) ? funct : 6'($urandom);
            if (exp_q[c] == 4'd0)
                bus.mem_ready = (c >= wf);
            else if (exp_q[c] == 4'd3 || exp_q[c] == 4'd5)
                bus.mem_ready = ((c - mem_first) >= wm);
            else
                bus.mem_ready = 1'($urandom);
            @(negedge clk);
            done = (c == last);
            es = {(c == wf), (c == wf),
                  done && (op == 2'b00 || (op == 2'b01 && funct[0])),
                  (exp_q[c] == 4'd5),
                  done && (op == 2'b10),
                  done && (op == 2'b11),
                  done};
            n_total++;
            if (bus.state !== exp_q[c])
                $display("FAIL %s state c%0d: got %0d want %0d", name, c, bus.state, exp_q[c]);
            else n_pass++;
            n_total++;
            if (obs_strb() !== es)
                $display("FAIL %s strobes c%0d: got %b want %b", name, c, obs_strb(), es);
            else n_pass++;
            n_total++;
            if (obs_sel() !== exp_sel(exp_q[c]))
                $display("FAIL %s selects c%0d: got %b want %b", name, c, obs_sel(), exp_sel(exp_q[c]));
            else n_pass++;
            n_total++;
            if (bus.imm_src !== eimm)
                $display("FAIL %s imm_src c%0d: got %b want %b", name, c, bus.imm_src, eimm);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.op        = 2'b00;
        bus.funct     = 6'd0;
        bus.mem_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if (bus.state !== 4'd0) $display("FAIL reset state: got %0d want 0", bus.state);
            else n_pass++;
            n_total++;
            if (obs_strb() !== 7'd0) $display("FAIL reset strobes: got %b want 0", obs_strb());
            else n_pass++;
            n_total++;
            if (obs_sel() !== exp_sel(4'd0)) $display("FAIL reset selects: got %b want %b", obs_sel(), exp_sel(4'd0));
            else n_pass++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(2'b00, 6'b000000, 0, 0, "post_reset");
    endtask

    task automatic test_dp();
        run_instr(2'b00, 6'b000000, 0, 0, "dp_reg");
        run_instr(2'b00, 6'b100000, 0, 0, "dp_imm");
    endtask

    task automatic test_ldr_wait();
        run_instr(2'b01, 6'b000001, 0, 2, "ldr_wait");
    endtask

    task automatic test_str_fetch_wait();
        run_instr(2'b01, 6'b000000, 1, 0, "str_fwait");
        run_instr(2'b01, 6'b000000, 0, 2, "str_mwait");
    endtask

    task automatic test_branch();
        run_instr(2'b10, 6'($urandom), 0, 0, "branch");
    endtask

    task automatic test_illegal();
        run_instr(2'b11, 6'($urandom), 0, 0, "illegal");
    endtask

    task automatic test_reset_mid();
        bus.op        = 2'b01;
        bus.funct     = 6'b000001;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.state !== 4'd3) $display("FAIL rst_mid pre state: got %0d want 3", bus.state);
        else n_pass++;
        @(posedge clk);
        #2;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        n_total++;
        if (bus.state !== 4'd0) $display("FAIL rst_mid state: got %0d want 0", bus.state);
        else n_pass++;
        n_total++;
        if (obs_strb() !== 7'd0) $display("FAIL rst_mid strobes: got %b want 0", obs_strb());
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(2'($urandom), 6'($urandom), 0, 0, "rst_release");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_instr(2'($urandom), 6'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_dp();
        test_ldr_wait();
        test_str_fetch_wait();
        test_branch();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule
